validacao_cedula_credito: RTL and testbench

Registered, parametrised successor to the combinational banknote-entry check. Samples note strobes while the vending FSM is in the entry state (state_entrada == 000) and validates the denomination. Valid notes accumulate into a credit register; the block runs its own inactivity timeout counter. Errors (sensor, invalid note, timeout, overflow) are latched in erro_code until acknowledged by the main FSM.

---
 rtl/validacao_cedula_credito_if.sv | 45 ++++
 rtl/validacao_cedula_credito.sv | 200 ++++++++++++++++++++
 tb/tb_validacao_cedula_credito.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/validacao_cedula_credito_if.sv
// Bus between the vending main FSM (master) and the banknote credit validator (slave).
// Escrow handshake signals exist only when CEDULA_ESCROW_EN is defined.
interface validacao_cedula_credito_if #(
  parameter int NOTE_W = 8,
  parameter int CRED_W = 10
);
  logic [NOTE_W-1:0] entrada_nota;
  logic              nota_strobe;
  logic              atividade;
  logic [2:0]        erro;
  logic [2:0]        state_entrada;
  logic              err_ack;
  logic              clear_credit;
  logic              clear;
  logic [2:0]        erro_code;
  logic [NOTE_W-1:0] nota;
  logic              nota_ok;
  logic [CRED_W-1:0] credito;
  logic              busy;
`ifdef CEDULA_ESCROW_EN
  logic              confirma;
  logic              devolve;
  logic              devolve_nota;

  modport master (
    output entrada_nota, nota_strobe, atividade, erro, state_entrada, err_ack, clear_credit,
           confirma, devolve,
    input  clear, erro_code, nota, nota_ok, credito, busy, devolve_nota
  );
  modport slave (
    input  entrada_nota, nota_strobe, atividade, erro, state_entrada, err_ack, clear_credit,
           confirma, devolve,
    output clear, erro_code, nota, nota_ok, credito, busy, devolve_nota
  );
`else
  modport master (
    output entrada_nota, nota_strobe, atividade, erro, state_entrada, err_ack, clear_credit,
    input  clear, erro_code, nota, nota_ok, credito, busy
  );
  modport slave (
    input  entrada_nota, nota_strobe, atividade, erro, state_entrada, err_ack, clear_credit,
    output clear, erro_code, nota, nota_ok, credito, busy
  );
`endif
endinterface

// File: rtl/validacao_cedula_credito.sv
// Registered banknote validator with credit accumulation, inactivity timeout and latched errors.
// Optional macro CEDULA_ESCROW_EN holds each accepted note in escrow until confirma/devolve.
//
// state   | meaning
// IDLE    | main FSM not in note entry; timer held at 0
// COLLECT | accepting notes, inactivity timer running
// ERROR   | erro_code latched until err_ack
module validacao_cedula_credito #(
  parameter int NOTE_W      = 8,
  parameter int CRED_W      = 10,
  parameter int MAX_CREDIT  = 200,
  parameter int TIMEOUT_CYC = 1000
) (
  input logic                        clk,
  input logic                        reset,
  validacao_cedula_credito_if.slave  bus
);
  localparam int SUM_W = ((CRED_W > NOTE_W) ? CRED_W : NOTE_W) + 1;
  localparam int TMR_W = $clog2(TIMEOUT_CYC);
  localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [SUM_W-1:0] MAX_SUM  = SUM_W'(MAX_CREDIT);

  localparam logic [2:0] ERR_NONE = 3'b000;
  localparam logic [2:0] ERR_NOTE = 3'b001;
  localparam logic [2:0] ERR_TMO  = 3'b011;
  localparam logic [2:0] ERR_OVF  = 3'b100;

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_ERROR} state_t;

  state_t            state, state_n;
  logic [TMR_W-1:0]  timer, timer_n;
  logic              clear_n, nota_ok_n, busy_n;
  logic [2:0]        code_n;
  logic [NOTE_W-1:0] nota_n;
  logic [CRED_W-1:0] cred_n;

  logic              entry, note_valid, strobe_blocked;
  logic [SUM_W-1:0]  cred_base, note_sum;

  function automatic logic is_denomination(input logic [NOTE_W-1:0] v);
    return (v == NOTE_W'(2))  || (v == NOTE_W'(5))  || (v == NOTE_W'(10)) ||
           (v == NOTE_W'(20)) || (v == NOTE_W'(50)) || (v == NOTE_W'(100));
  endfunction

  assign entry      = (bus.state_entrada == 3'b000);
  assign note_valid = is_denomination(bus.entrada_nota);
  // Credit consumed this cycle does not count toward overflow of a note arriving with it.
  assign cred_base  = bus.clear_credit ? '0 : SUM_W'(bus.credito);
  assign note_sum   = cred_base + SUM_W'(bus.entrada_nota);

`ifdef CEDULA_ESCROW_EN
  logic              esc_full, esc_full_n, dev_n;
  logic [NOTE_W-1:0] esc_val, esc_val_n;
  logic [SUM_W-1:0]  esc_sum;
  assign esc_sum        = cred_base + SUM_W'(esc_val);
  assign strobe_blocked = esc_full;
`else
  assign strobe_blocked = 1'b0;
`endif

  always_comb begin
    state_n   = state;
    timer_n   = timer;
    clear_n   = 1'b0;
    nota_ok_n = 1'b0;
    code_n    = bus.erro_code;
    nota_n    = bus.nota;
    cred_n    = bus.clear_credit ? '0 : bus.credito;
`ifdef CEDULA_ESCROW_EN
    esc_full_n = esc_full;
    esc_val_n  = esc_val;
    dev_n      = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        timer_n = '0;
        if (entry) state_n = S_COLLECT;
      end
      S_COLLECT: begin
        if (!entry) begin
          state_n = S_IDLE;
          timer_n = '0;
        end else if (bus.erro == 3'b001) begin
          state_n = S_ERROR;
          code_n  = ERR_NOTE;
          timer_n = '0;
        end else if (bus.nota_strobe && bus.atividade) begin
          if (!note_valid || strobe_blocked) begin
            state_n = S_ERROR;
            code_n  = ERR_NOTE;
            timer_n = '0;
          end else begin
`ifdef CEDULA_ESCROW_EN
            esc_full_n = 1'b1;
            esc_val_n  = bus.entrada_nota;
            clear_n    = 1'b1;
            timer_n    = '0;
`else
            if (note_sum > MAX_SUM) begin
              state_n = S_ERROR;
              code_n  = ERR_OVF;
              timer_n = '0;
            end else begin
              cred_n    = CRED_W'(note_sum);
              nota_n    = bus.entrada_nota;
              nota_ok_n = 1'b1;
              clear_n   = 1'b1;
              timer_n   = '0;
            end
`endif
          end
`ifdef CEDULA_ESCROW_EN
        end else if (bus.confirma && esc_full) begin
          // Escrow stays full on overflow so the user can still ask for the note back.
          if (esc_sum > MAX_SUM) begin
            state_n = S_ERROR;
            code_n  = ERR_OVF;
            timer_n = '0;
          end else begin
            cred_n     = CRED_W'(esc_sum);
            nota_n     = esc_val;
            nota_ok_n  = 1'b1;
            esc_full_n = 1'b0;
            clear_n    = 1'b1;
            timer_n    = '0;
          end
        end else if (bus.devolve && esc_full) begin
          dev_n      = 1'b1;
          esc_full_n = 1'b0;
          clear_n    = 1'b1;
          timer_n    = '0;
`endif
        end else if (bus.atividade) begin
          clear_n = 1'b1;
          timer_n = '0;
        end else if (timer == TMO_LAST) begin
          state_n = S_ERROR;
          code_n  = ERR_TMO;
          timer_n = '0;
`ifdef CEDULA_ESCROW_EN
          if (esc_full) begin
            dev_n      = 1'b1;
            esc_full_n = 1'b0;
          end
`endif
        end else begin
          timer_n = timer + 1'b1;
        end
      end
      S_ERROR: begin
        timer_n = '0;
        if (bus.err_ack) begin
          code_n  = ERR_NONE;
          state_n = entry ? S_COLLECT : S_IDLE;
        end
      end
      default: begin
        state_n = S_IDLE;
        timer_n = '0;
      end
    endcase
    busy_n = (state_n != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      timer         <= '0;
      bus.clear     <= 1'b0;
      bus.erro_code <= ERR_NONE;
      bus.nota      <= '0;
      bus.nota_ok   <= 1'b0;
      bus.credito   <= '0;
      bus.busy      <= 1'b0;
    end else begin
      state         <= state_n;
      timer         <= timer_n;
      bus.clear     <= clear_n;
      bus.erro_code <= code_n;
      bus.nota      <= nota_n;
      bus.nota_ok   <= nota_ok_n;
      bus.credito   <= cred_n;
      bus.busy      <= busy_n;
    end
  end

`ifdef CEDULA_ESCROW_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      esc_full         <= 1'b0;
      esc_val          <= '0;
      bus.devolve_nota <= 1'b0;
    end else begin
      esc_full         <= esc_full_n;
      esc_val          <= esc_val_n;
      bus.devolve_nota <= dev_n;
    end
  end
`endif
endmodule

// File: tb/tb_validacao_cedula_credito.sv
// Bench for validacao_cedula_credito: directed test-plan scenarios plus randomized traffic
// compared every cycle against a cycle-level behavioural model of the note-entry rules.
module tb_validacao_cedula_credito;
  localparam int NOTE_W      = 8;
  localparam int CRED_W      = 10;
  localparam int MAX_CREDIT  = 100;
  localparam int TIMEOUT_CYC = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  validacao_cedula_credito_if #(.NOTE_W(NOTE_W), .CRED_W(CRED_W)) bus ();

  validacao_cedula_credito #(
    .NOTE_W(NOTE_W), .CRED_W(CRED_W), .MAX_CREDIT(MAX_CREDIT), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: session mode, quiet-cycle count, and the expected output values.
  int m_mode;   // 0 waiting for entry, 1 taking notes, 2 error latched
  int m_quiet, m_cred, m_code, m_nota, m_ok, m_clr, m_busy;
  int m_escf, m_escv, m_dev;

  function automatic bit denomination_ok(input int v);
    return v inside {2, 5, 10, 20, 50, 100};
  endfunction

  task automatic m_fail(input int code);
    m_mode  = 2;
    m_code  = code;
    m_quiet = 0;
  endtask

  task automatic model_step();
    int base, v;
    bit conf, dev;
    conf = 1'b0;
    dev  = 1'b0;
`ifdef CEDULA_ESCROW_EN
    conf = bus.confirma;
    dev  = bus.devolve;
`endif
    m_ok = 0; m_clr = 0; m_dev = 0;
    if (reset) begin
      m_mode = 0; m_quiet = 0; m_cred = 0; m_code = 0; m_nota = 0;
      m_escf = 0; m_escv = 0; m_busy = 0;
      return;
    end
    v    = int'(bus.entrada_nota);
    base = bus.clear_credit ? 0 : m_cred;
    m_cred = base;
    if (m_mode == 0) begin
      m_quiet = 0;
      if (bus.state_entrada == 3'd0) m_mode = 1;
    end else if (m_mode == 1) begin
      if (bus.state_entrada != 3'd0) begin
        m_mode = 0; m_quiet = 0;
      end else if (bus.erro == 3'd1) begin
        m_fail(1);
      end else if (bus.nota_strobe && bus.atividade) begin
        if (!denomination_ok(v) || m_escf != 0) m_fail(1);
`ifdef CEDULA_ESCROW_EN
        else begin m_escf = 1; m_escv = v; m_clr = 1; m_quiet = 0; end
`else
        else if (base + v > MAX_CREDIT) m_fail(4);
        else begin m_cred = base + v; m_nota = v; m_ok = 1; m_clr = 1; m_quiet = 0; end
`endif
      end else if (conf && m_escf != 0) begin
        if (base + m_escv > MAX_CREDIT) m_fail(4);
        else begin m_cred = base + m_escv; m_nota = m_escv; m_ok = 1; m_escf = 0; m_clr = 1; m_quiet = 0; end
      end else if (dev && m_escf != 0) begin
        m_dev = 1; m_escf = 0; m_clr = 1; m_quiet = 0;
      end else if (bus.atividade) begin
        m_clr = 1; m_quiet = 0;
      end else begin
        m_quiet++;
        if (m_quiet == TIMEOUT_CYC) begin
          m_fail(3);
          if (m_escf != 0) begin m_dev = 1; m_escf = 0; end
        end
      end
    end else begin
      m_quiet = 0;
      if (bus.err_ack) begin
        m_code = 0;
        m_mode = (bus.state_entrada == 3'd0) ? 1 : 0;
      end
    end
    m_busy = (m_mode != 0) ? 1 : 0;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("clear",     bus.clear,     m_clr);
    chk("erro_code", bus.erro_code, m_code);
    chk("nota",      bus.nota,      m_nota);
    chk("nota_ok",   bus.nota_ok,   m_ok);
    chk("credito",   bus.credito,   m_cred);
    chk("busy",      bus.busy,      m_busy);
`ifdef CEDULA_ESCROW_EN
    chk("devolve_nota", bus.devolve_nota, m_dev);
`endif
  endtask

  task automatic quiet_inputs();
    bus.nota_strobe  = 1'b0;
    bus.atividade    = 1'b0;
    bus.err_ack      = 1'b0;
    bus.clear_credit = 1'b0;
    bus.erro         = 3'd0;
`ifdef CEDULA_ESCROW_EN
    bus.confirma = 1'b0;
    bus.devolve  = 1'b0;
`endif
  endtask

  task automatic put_note(input int v);
    bus.entrada_nota = NOTE_W'(v);
    bus.nota_strobe  = 1'b1;
    bus.atividade    = 1'b1;
    tick();
    quiet_inputs();
  endtask

  task automatic count_to_timeout(input string tag);
    int n;
    n = 0;
    while (bus.erro_code != 3'b011 && n < 40) begin
      tick();
      n++;
    end
    chk(tag, n, TIMEOUT_CYC);
  endtask

  task automatic pulse_ack();
    bus.err_ack = 1'b1;
    tick();
    bus.err_ack = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r;
    reset = 1'b1;
    quiet_inputs();
    bus.state_entrada = 3'd0;
    bus.entrada_nota  = 8'd50;
    bus.nota_strobe   = 1'b1;
    bus.atividade     = 1'b1;
    repeat (3) tick();
    chk("rst_credito", bus.credito, 0);
    chk("rst_busy",    bus.busy,    0);
    chk("rst_nota_ok", bus.nota_ok, 0);
    reset = 1'b0;
    quiet_inputs();

    tick();
    chk("enter_busy", bus.busy, 1);
    put_note(5);
    chk("n5_nota", bus.nota, 5);
    chk("n5_ok",   bus.nota_ok, 1);
    chk("n5_clear", bus.clear, 1);
    put_note(20);
    chk("n20_nota", bus.nota, 20);
    chk("cred_25",  bus.credito, 25);
    chk("code_none", bus.erro_code, 0);

    put_note(7);
    chk("inv_code", bus.erro_code, 1);
    chk("inv_cred", bus.credito, 25);
    tick();
    pulse_ack();
    chk("ack_code", bus.erro_code, 0);
    chk("ack_busy", bus.busy, 1);

    count_to_timeout("tmo_cycles");
    pulse_ack();
    repeat (9) tick();
    bus.atividade = 1'b1;
    tick();
    bus.atividade = 1'b0;
    count_to_timeout("tmo_after_act");
    pulse_ack();

    bus.clear_credit = 1'b1;
    tick();
    bus.clear_credit = 1'b0;
    chk("cc_zero", bus.credito, 0);
`ifndef CEDULA_ESCROW_EN
    put_note(50);
    put_note(50);
    chk("cred_100", bus.credito, 100);
    put_note(2);
    chk("ovf_code", bus.erro_code, 4);
    chk("ovf_cred", bus.credito, 100);
    pulse_ack();
    bus.clear_credit = 1'b1;
    put_note(10);
    chk("cc_note_cred", bus.credito, 10);
`endif
    bus.state_entrada = 3'd2;
    tick();
    chk("leave_busy", bus.busy, 0);
    bus.state_entrada = 3'd0;

    for (int i = 0; i < 2500; i++) begin
      reset             = ($urandom_range(0, 199) == 0);
      r                 = $urandom_range(0, 99);
      bus.state_entrada = (r < 92) ? 3'd0 : 3'($urandom_range(1, 7));
      bus.nota_strobe   = ($urandom_range(0, 99) < 20);
      bus.atividade     = ($urandom_range(0, 99) < ((i % 400 < 200) ? 40 : 5));
      bus.entrada_nota  = ($urandom_range(0, 9) < 7)
                          ? NOTE_W'($urandom_range(0, 5) == 0 ? 100 : 0) : NOTE_W'($urandom_range(0, 255));
      if (bus.entrada_nota == 0) begin
        case ($urandom_range(0, 4))
          0: bus.entrada_nota = 8'd2;
          1: bus.entrada_nota = 8'd5;
          2: bus.entrada_nota = 8'd10;
          3: bus.entrada_nota = 8'd20;
          default: bus.entrada_nota = 8'd50;
        endcase
      end
      bus.erro          = ($urandom_range(0, 49) == 0) ? 3'd1 : 3'($urandom_range(0, 1) * 2);
      bus.err_ack       = ($urandom_range(0, 99) < 20);
      bus.clear_credit  = ($urandom_range(0, 99) < 4);
`ifdef CEDULA_ESCROW_EN
      bus.confirma = ($urandom_range(0, 99) < 15);
      bus.devolve  = ($urandom_range(0, 99) < 8);
`endif
      tick();
    end
    reset = 1'b0;
    quiet_inputs();

`ifdef CEDULA_ESCROW_EN
    reset = 1'b1;
    bus.state_entrada = 3'd0;
    tick();
    reset = 1'b0;
    tick();
    put_note(20);
    chk("esc_hold_cred", bus.credito, 0);
    bus.devolve = 1'b1;
    tick();
    bus.devolve = 1'b0;
    chk("esc_devolve", bus.devolve_nota, 1);
    chk("esc_dev_cred", bus.credito, 0);
    put_note(50);
    bus.confirma = 1'b1;
    tick();
    bus.confirma = 1'b0;
    chk("esc_conf_cred", bus.credito, 50);
    chk("esc_conf_ok", bus.nota_ok, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
